// File: rtl/spare_row_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// spare_row_alloc_ctrl_if
//   Fault-in / result-out handshake bundle for the spare-row allocation
//   controller.
//
//   fault_valid  producer -> ctrl  fault address offered
//   fault_row    producer -> ctrl  {block, addr} of the faulty row
//   fault_ready  ctrl -> producer  controller can accept a fault
//   result_valid ctrl -> producer  one-cycle pulse per processed fault
//   result_code  ctrl -> producer  00 covered, 01 allocated, 10 unrepairable
//   alloc_idx    ctrl -> producer  spare index used when result_code = 01
//
//   master modport: fault producer.  slave modport: the controller.
// ---------------------------------------------------------------------------
interface spare_row_alloc_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int BLK_W  = 2
);
  logic                    fault_valid;
  logic [ADDR_W+BLK_W-1:0] fault_row;
  logic                    fault_ready;
  logic                    result_valid;
  logic [1:0]              result_code;
  logic [1:0]              alloc_idx;

  modport master (
    output fault_valid, fault_row,
    input  fault_ready, result_valid, result_code, alloc_idx
  );

  modport slave (
    input  fault_valid, fault_row,
    output fault_ready, result_valid, result_code, alloc_idx
  );
endinterface

// File: rtl/spare_row_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// spare_row_alloc_ctrl
//   Sequencing controller for the 4-entry spare-row comparator (NP_comp).
//   Each accepted faulty row is registered onto npr; the comparator answers
//   on comp one cycle later. A hit means the row is already covered.
//   A miss allocates the lowest free spare. A miss with all spares used
//   flags the die unrepairable and parks the controller until reset/clear.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   clear          synchronous soft clear, same effect as reset, highest priority
//   bus            spare_row_alloc_ctrl_if.slave : fault handshake + result
//   npr            registered fault row, to comparator NPr
//   rrx1..rrx4     allocated spare rows, to comparator RRx1..RRx4
//   rlss           spare-used bits (bit i = spare i+1 valid), to comparator RLSS
//   comp           comparator hit, combinational from npr/rrx/rlss
//   unrepairable   sticky fail flag
//   spares_used    number of allocated spares, 0..4
//   hit_cnt,
//   alloc_cnt      saturating covered/allocated counters; present only
//                  when the FAULT_STATS_EN macro is defined
// ---------------------------------------------------------------------------
module spare_row_alloc_ctrl #(
  parameter int ADDR_W = 10,
  parameter int BLK_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  spare_row_alloc_ctrl_if.slave   bus,
  output logic [ADDR_W+BLK_W-1:0] npr,
  output logic [ADDR_W+BLK_W-1:0] rrx1,
  output logic [ADDR_W+BLK_W-1:0] rrx2,
  output logic [ADDR_W+BLK_W-1:0] rrx3,
  output logic [ADDR_W+BLK_W-1:0] rrx4,
  output logic [3:0]              rlss,
  input  logic                    comp,
  output logic                    unrepairable,
  output logic [2:0]              spares_used
`ifdef FAULT_STATS_EN
  ,
  output logic [7:0]              hit_cnt,
  output logic [7:0]              alloc_cnt
`endif
);

  localparam int ROW_W  = ADDR_W + BLK_W;
  localparam int SPARES = 4;

  localparam logic [1:0] CODE_COVERED = 2'b00;
  localparam logic [1:0] CODE_ALLOC   = 2'b01;
  localparam logic [1:0] CODE_UNREP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t             state_reg;
  logic [ROW_W-1:0]   npr_reg;
  logic [SPARES-1:0]  rlss_vec;
  logic [2:0]         used_reg;
  logic               fault_ready_reg;
  logic               result_valid_reg;
  logic [1:0]         result_code_reg;
  logic [1:0]         alloc_idx_reg;
  logic               unrep_reg;
`ifdef FAULT_STATS_EN
  logic [7:0]         hit_cnt_reg;
  logic [7:0]         alloc_cnt_reg;
`endif

  // Lowest free spare. Only meaningful while some rlss bit is clear.
  logic [1:0] free_idx;
  logic       all_used;
  logic       alloc_do;

  always_comb begin
    free_idx = 2'd0;
    for (int i = SPARES - 1; i >= 0; i--) begin
      if (!rlss_vec[i]) free_idx = 2'(i);
    end
  end

  assign all_used = &rlss_vec;
  // comp is sampled at the end of the CMP cycle, once it has settled on npr.
  assign alloc_do = (state_reg == CMP) && !comp && !all_used;

  // Per-spare storage. An entry is written exactly once, when its used bit
  // goes from 0 to 1; after that it only changes on reset/clear.
  logic [ROW_W-1:0] rrx_arr [SPARES];

  generate
    for (genvar gi = 0; gi < SPARES; gi++) begin : g_spare
      logic [ROW_W-1:0] row_reg;
      logic             used_reg_bit;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg      <= '0;
          used_reg_bit <= 1'b0;
        end else if (clear) begin
          row_reg      <= '0;
          used_reg_bit <= 1'b0;
        end else if (alloc_do && (free_idx == 2'(gi))) begin
          row_reg      <= npr_reg;
          used_reg_bit <= 1'b1;
        end
      end

      assign rlss_vec[gi] = used_reg_bit;
      assign rrx_arr[gi]  = row_reg;
    end
  endgenerate

  // Control FSM. All handshake/result outputs are registered here;
  // fault_ready tracks the next state so it never depends on fault_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      npr_reg          <= '0;
      used_reg         <= 3'd0;
      fault_ready_reg  <= 1'b1;
      result_valid_reg <= 1'b0;
      result_code_reg  <= CODE_COVERED;
      alloc_idx_reg    <= 2'd0;
      unrep_reg        <= 1'b0;
`ifdef FAULT_STATS_EN
      hit_cnt_reg      <= 8'd0;
      alloc_cnt_reg    <= 8'd0;
`endif
    end else if (clear) begin
      // Discards any fault in CMP; no result is issued for it.
      state_reg        <= IDLE;
      npr_reg          <= '0;
      used_reg         <= 3'd0;
      fault_ready_reg  <= 1'b1;
      result_valid_reg <= 1'b0;
      result_code_reg  <= CODE_COVERED;
      alloc_idx_reg    <= 2'd0;
      unrep_reg        <= 1'b0;
`ifdef FAULT_STATS_EN
      hit_cnt_reg      <= 8'd0;
      alloc_cnt_reg    <= 8'd0;
`endif
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.fault_valid) begin
            npr_reg         <= bus.fault_row;
            state_reg       <= CMP;
            fault_ready_reg <= 1'b0;
          end
        end
        CMP: begin
          result_valid_reg <= 1'b1;
          if (comp) begin
            result_code_reg <= CODE_COVERED;
            state_reg       <= IDLE;
            fault_ready_reg <= 1'b1;
`ifdef FAULT_STATS_EN
            if (hit_cnt_reg != 8'hFF) hit_cnt_reg <= hit_cnt_reg + 8'd1;
`endif
          end else if (!all_used) begin
            result_code_reg <= CODE_ALLOC;
            alloc_idx_reg   <= free_idx;
            used_reg        <= used_reg + 3'd1;
            state_reg       <= IDLE;
            fault_ready_reg <= 1'b1;
`ifdef FAULT_STATS_EN
            if (alloc_cnt_reg != 8'hFF) alloc_cnt_reg <= alloc_cnt_reg + 8'd1;
`endif
          end else begin
            result_code_reg <= CODE_UNREP;
            unrep_reg       <= 1'b1;
            state_reg       <= FAIL;
            fault_ready_reg <= 1'b0;
          end
        end
        FAIL: begin
          // Parked until reset or clear.
          state_reg       <= FAIL;
          fault_ready_reg <= 1'b0;
        end
        default: begin
          state_reg       <= IDLE;
          fault_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.fault_ready  = fault_ready_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.result_code  = result_code_reg;
  assign bus.alloc_idx    = alloc_idx_reg;

  assign npr          = npr_reg;
  assign rrx1         = rrx_arr[0];
  assign rrx2         = rrx_arr[1];
  assign rrx3         = rrx_arr[2];
  assign rrx4         = rrx_arr[3];
  assign rlss         = rlss_vec;
  assign unrepairable = unrep_reg;
  assign spares_used  = used_reg;
`ifdef FAULT_STATS_EN
  assign hit_cnt      = hit_cnt_reg;
  assign alloc_cnt    = alloc_cnt_reg;
`endif

endmodule

// File: tb/tb_spare_row_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spare_row_alloc_ctrl
//   Directed scenarios followed by randomized faults. A behavioural model
//   (list of allocated rows + sticky fail bit) predicts every result; the
//   4-entry comparator is modelled combinationally from the DUT's outputs.
// ---------------------------------------------------------------------------
module tb_spare_row_alloc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [11:0] npr, rrx1, rrx2, rrx3, rrx4;
  logic [3:0]  rlss;
  logic        comp;
  logic        unrepairable;
  logic [2:0]  spares_used;
`ifdef FAULT_STATS_EN
  logic [7:0]  hit_cnt, alloc_cnt;
`endif

  spare_row_alloc_ctrl_if #(.ADDR_W(10), .BLK_W(2)) bus ();

  spare_row_alloc_ctrl #(.ADDR_W(10), .BLK_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .bus          (bus),
    .npr          (npr),
    .rrx1         (rrx1),
    .rrx2         (rrx2),
    .rrx3         (rrx3),
    .rrx4         (rrx4),
    .rlss         (rlss),
    .comp         (comp),
    .unrepairable (unrepairable),
    .spares_used  (spares_used)
`ifdef FAULT_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .alloc_cnt    (alloc_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Comparator NP_comp: hit when any valid spare holds exactly npr.
  assign comp = (rlss[0] && (rrx1 == npr)) || (rlss[1] && (rrx2 == npr)) ||
                (rlss[2] && (rrx3 == npr)) || (rlss[3] && (rrx4 == npr));

  logic [11:0] rrx_obs [4];
  assign rrx_obs[0] = rrx1;
  assign rrx_obs[1] = rrx2;
  assign rrx_obs[2] = rrx3;
  assign rrx_obs[3] = rrx4;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int n_results = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [11:0] m_rows [$];
  bit          m_unrep;
  int          m_hit;
  int          m_alloc;

  typedef struct {
    logic [11:0] row;
    logic [1:0]  code;
    logic [1:0]  idx;
    int          cyc;
  } exp_t;

  exp_t        exp_q [$];
  logic [1:0]  obs_code_q [$];
  logic [1:0]  obs_idx_q [$];

  function automatic void model_reset();
    m_rows.delete();
    m_unrep = 1'b0;
    m_hit   = 0;
    m_alloc = 0;
  endfunction

  function automatic exp_t predict(input logic [11:0] row);
    exp_t e;
    bit   hit = 1'b0;
    foreach (m_rows[i]) if (m_rows[i] == row) hit = 1'b1;
    e.row = row;
    e.cyc = cyc;
    e.idx = 2'd0;
    if (hit) begin
      e.code = 2'b00;
      if (m_hit < 255) m_hit++;
    end else if (m_rows.size() < 4) begin
      e.code = 2'b01;
      e.idx  = 2'(m_rows.size());
      m_rows.push_back(row);
      if (m_alloc < 255) m_alloc++;
    end else begin
      e.code  = 2'b10;
      m_unrep = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [3:0] model_rlss();
    return 4'((1 << m_rows.size()) - 1);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      model_reset();
      check("rv_in_reset", bus.result_valid, 0);
    end else begin
      if (bus.result_valid) begin
        n_results++;
        if (exp_q.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("[%0t] result row=0x%03h code=%0d idx=%0d rlss=%b used=%0d",
                   $time, e.row, bus.result_code, bus.alloc_idx, rlss, spares_used);
          obs_code_q.push_back(bus.result_code);
          obs_idx_q.push_back(bus.alloc_idx);
          check("latency", cyc - e.cyc, 2);
          check("result_code", bus.result_code, e.code);
          if (e.code == 2'b01) check("alloc_idx", bus.alloc_idx, e.idx);
          check("npr", npr, e.row);
          check("rlss", rlss, model_rlss());
          check("spares_used", spares_used, m_rows.size());
          check("unrepairable", unrepairable, m_unrep);
          for (int i = 0; i < 4; i++)
            check($sformatf("rrx%0d", i + 1), rrx_obs[i],
                  (i < m_rows.size()) ? m_rows[i] : 12'h000);
`ifdef FAULT_STATS_EN
          check("hit_cnt", hit_cnt, m_hit);
          check("alloc_cnt", alloc_cnt, m_alloc);
`endif
        end
      end
      // Ready exactly when idle: nothing in flight and not failed.
      check("fault_ready", bus.fault_ready, (exp_q.size() == 0) && !m_unrep);
      if (clear) begin
        exp_q.delete();
        model_reset();
      end else if (bus.fault_valid && bus.fault_ready) begin
        exp_q.push_back(predict(bus.fault_row));
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+#1) ----------------
  task automatic send_fault(input logic [11:0] row);
    int n = 0;
    while (!bus.fault_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check("ready_timeout", 0, 1);
    end else begin
      bus.fault_valid = 1'b1;
      bus.fault_row   = row;
      @(posedge clk); #1;
      bus.fault_valid = 1'b0;
      bus.fault_row   = 12'($urandom);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("done_timeout", 0, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [1:0] code, input logic [1:0] idx);
    logic [1:0] c, i;
    if (obs_code_q.size() == 0) begin
      check({tag, "_missing"}, 0, 1);
    end else begin
      c = obs_code_q.pop_front();
      i = obs_idx_q.pop_front();
      check({tag, "_code"}, c, code);
      if (code == 2'b01) check({tag, "_idx"}, i, idx);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_npr"}, npr, 0);
    check({tag, "_rrx1"}, rrx1, 0);
    check({tag, "_rrx2"}, rrx2, 0);
    check({tag, "_rrx3"}, rrx3, 0);
    check({tag, "_rrx4"}, rrx4, 0);
    check({tag, "_rlss"}, rlss, 0);
    check({tag, "_used"}, spares_used, 0);
    check({tag, "_rv"}, bus.result_valid, 0);
    check({tag, "_code"}, bus.result_code, 0);
    check({tag, "_idx"}, bus.alloc_idx, 0);
    check({tag, "_unrep"}, unrepairable, 0);
    check({tag, "_ready"}, bus.fault_ready, 1);
`ifdef FAULT_STATS_EN
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_alloc_cnt"}, alloc_cnt, 0);
`endif
  endtask

  // ---------------- main sequence ----------------
  logic [11:0] seq4 [4]  = '{12'h001, 12'h002, 12'h003, 12'h004};
  logic [11:0] srows [3] = '{12'h010, 12'h011, 12'h010};
  logic [9:0]  pool [6]  = '{10'h005, 10'h010, 10'h011, 10'h3FF, 10'h000, 10'h123};

  initial begin
    int   base;
    int   sidx;
    logic r;
    logic [11:0] row;

    bus.fault_valid = 1'b0;
    bus.fault_row   = 12'h000;
    #1 rst_n = 1'b0;
    #2 check_reset_state("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("after_rst");

    // Single fault allocates spare 0.
    send_fault(12'h005);
    wait_done();
    expect_res("t1", 2'b01, 2'd0);
    check("t1_rrx1", rrx1, 12'h005);
    check("t1_rlss", rlss, 4'b0001);
    check("t1_used", spares_used, 1);

    // Repeat of a covered row.
    send_fault(12'h005);
    wait_done();
    expect_res("t2", 2'b00, 2'd0);
    check("t2_rlss", rlss, 4'b0001);
    check("t2_used", spares_used, 1);

    // Same address in another block is a distinct row.
    do_clear();
    send_fault(12'h005);
    send_fault(12'h405);
    wait_done();
    expect_res("t3a", 2'b01, 2'd0);
    expect_res("t3b", 2'b01, 2'd1);
    check("t3_rrx1", rrx1, 12'h005);
    check("t3_rrx2", rrx2, 12'h405);
    check("t3_rlss", rlss, 4'b0011);

    // Exhaust spares, then one more.
    do_clear();
    for (int k = 0; k < 4; k++) send_fault(seq4[k]);
    send_fault(12'h009);
    wait_done();
    for (int k = 0; k < 4; k++) expect_res($sformatf("t4_%0d", k), 2'b01, 2'(k));
    expect_res("t4_fail", 2'b10, 2'd0);
    check("t4_unrep", unrepairable, 1);
    check("t4_rlss", rlss, 4'b1111);
    bus.fault_valid = 1'b1;
    bus.fault_row   = 12'h00A;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t4_fail_ready", bus.fault_ready, 0);
    end
    @(posedge clk); #1;
    bus.fault_valid = 1'b0;
    check("t4_rrx4_frozen", rrx4, 12'h004);
    do_clear();
    check_reset_state("t4_clear");

    // Asynchronous reset in the middle of CMP.
    send_fault(12'h123);
    check("t5_npr_before", npr, 12'h123);
    rst_n = 1'b0;
    #1 check_reset_state("t5_rst");
    @(negedge clk);
    check("t5_no_rv", bus.result_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    obs_code_q.delete();
    obs_idx_q.delete();
    send_fault(12'h123);
    wait_done();
    expect_res("t5", 2'b01, 2'd0);

    // fault_valid held high across three back-to-back faults.
    do_clear();
    obs_code_q.delete();
    obs_idx_q.delete();
    base = n_results;
    sidx = 0;
    bus.fault_row   = srows[0];
    bus.fault_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      r = bus.fault_ready;
      check($sformatf("t6_ready_%0d", k), r, (k % 2 == 0));
      @(posedge clk); #1;
      if (r && bus.fault_valid) begin
        sidx++;
        if (sidx < 3) bus.fault_row = srows[sidx];
        else bus.fault_valid = 1'b0;
      end
    end
    bus.fault_valid = 1'b0;
    wait_done();
    repeat (3) begin @(posedge clk); #1; end
    check("t6_pulses", n_results - base, 3);
    expect_res("t6a", 2'b01, 2'd0);
    expect_res("t6b", 2'b01, 2'd1);
    expect_res("t6c", 2'b00, 2'd0);

    // Randomized traffic, including clears that discard an in-flight fault.
    for (int t = 0; t < 300; t++) begin
      wait_done();
      if (unrepairable) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        do_clear();
      end
      row = {2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)]};
      send_fault(row);
      if ($urandom_range(0, 9) == 0) do_clear();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_done();
    repeat (2) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
